// File: rtl/mux_rr_t_pkg.sv
// Shared constants for the class-tagged word stream produced by mux_rr_t and consumed by demux_t.
package mux_rr_t_pkg;

    localparam int DEF_BITNUMBER = 6;
    localparam int DEF_CNTW      = 8;

    // The class bit sits just below the word MSB for any word width.
    function automatic int class_bit_of(input int bitnumber);
        return bitnumber - 2;
    endfunction

    localparam int CLASS_BIT = class_bit_of(DEF_BITNUMBER);
    localparam int SRC_P0    = 0;
    localparam int SRC_P1    = 1;

endpackage

// File: rtl/mux_rr_t_if.sv
// Source-FIFO / output-stream bundle of the two-source round-robin multiplexer.
import mux_rr_t_pkg::*;

interface mux_rr_t_if #(
    parameter int BITNUMBER = DEF_BITNUMBER,
    parameter int CNTW      = DEF_CNTW
);
    logic [BITNUMBER-1:0] data_P0;
    logic [BITNUMBER-1:0] data_P1;
    logic                 empty_P0;
    logic                 empty_P1;
    logic                 pause_D0;
    logic                 pause_D1;
    logic                 pop_P0;
    logic                 pop_P1;
    logic [BITNUMBER-1:0] Mux_out;
    logic                 Mux_valid;
    logic [CNTW-1:0]      cnt_P0;
    logic [CNTW-1:0]      cnt_P1;

    // master: the multiplexer itself; slave: the FIFOs and downstream logic around it.
    modport master (
        input  data_P0, data_P1, empty_P0, empty_P1, pause_D0, pause_D1,
        output pop_P0, pop_P1, Mux_out, Mux_valid, cnt_P0, cnt_P1
    );

    modport slave (
        output data_P0, data_P1, empty_P0, empty_P1, pause_D0, pause_D1,
        input  pop_P0, pop_P1, Mux_out, Mux_valid, cnt_P0, cnt_P1
    );

endinterface

// File: rtl/mux_rr_t_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not served most recently wins.
import mux_rr_t_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Reset to P1 so that P0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (grant[SRC_P0]) begin
            last <= 1'(SRC_P0);
        end else if (grant[SRC_P1]) begin
            last <= 1'(SRC_P1);
        end
    end

endmodule

// File: rtl/mux_rr_t.sv
// Round-robin merge of two FWFT source FIFOs into one registered stream, class bit forced to the source index.
import mux_rr_t_pkg::*;

module mux_rr_t #(
    parameter int BITNUMBER = DEF_BITNUMBER,
    parameter int CNTW      = DEF_CNTW
) (
    input logic        clk,
    input logic        reset,
    mux_rr_t_if.master bus
);

    localparam int CB = class_bit_of(BITNUMBER);

    logic [1:0]           req;
    logic [1:0]           grant;
    logic [BITNUMBER-1:0] word0;
    logic [BITNUMBER-1:0] word1;

    // Pause is used unregistered so a full destination never sees another pop.
    assign req[SRC_P0] = !reset && !bus.empty_P0 && !bus.pause_D0;
    assign req[SRC_P1] = !reset && !bus.empty_P1 && !bus.pause_D1;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    assign bus.pop_P0 = grant[SRC_P0];
    assign bus.pop_P1 = grant[SRC_P1];

    always_comb begin
        word0     = bus.data_P0;
        word0[CB] = 1'(SRC_P0);
        word1     = bus.data_P1;
        word1[CB] = 1'(SRC_P1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Mux_out   <= '0;
            bus.Mux_valid <= 1'b0;
            bus.cnt_P0    <= '0;
            bus.cnt_P1    <= '0;
        end else if (grant[SRC_P0]) begin
            bus.Mux_out   <= word0;
            bus.Mux_valid <= 1'b1;
            bus.cnt_P0    <= bus.cnt_P0 + CNTW'(1);
        end else if (grant[SRC_P1]) begin
            bus.Mux_out   <= word1;
            bus.Mux_valid <= 1'b1;
            bus.cnt_P1    <= bus.cnt_P1 + CNTW'(1);
        end else begin
            bus.Mux_out   <= '0;
            bus.Mux_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_t.sv
// Bench for mux_rr_t: queue-based FIFO/stream model checked every cycle plus literal pins.
module tb_mux_rr_t;
    import mux_rr_t_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mux_rr_t_if #(.BITNUMBER(6), .CNTW(8)) bus ();
    mux_rr_t_if #(.BITNUMBER(6), .CNTW(2)) bus_w ();

    mux_rr_t #(.BITNUMBER(6), .CNTW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    mux_rr_t #(.BITNUMBER(6), .CNTW(2)) dut_w (.clk(clk), .reset(reset), .bus(bus_w));

    assign bus_w.data_P0  = bus.data_P0;
    assign bus_w.data_P1  = bus.data_P1;
    assign bus_w.empty_P0 = bus.empty_P0;
    assign bus_w.empty_P1 = bus.empty_P1;
    assign bus_w.pause_D0 = bus.pause_D0;
    assign bus_w.pause_D1 = bus.pause_D1;

    int checks = 0;
    int errors = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    int m_last = 1, m_out = 0, m_valid = 0;
    int m_cnt0 = 0, m_cnt1 = 0, m_cw0 = 0, m_cw1 = 0;
    bit armed = 1'b0;
    logic seen0, seen1;

    logic [5:0] lit_c[6] = '{6'h20, 6'h11, 6'h21, 6'h12, 6'h22, 6'h13};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.data_P0  = (q0.size() > 0) ? q0[0] : 6'h00;
        bus.data_P1  = (q1.size() > 0) ? q1[0] : 6'h00;
        bus.empty_P0 = (q0.size() == 0);
        bus.empty_P1 = (q1.size() == 0);
    endtask

    // Which source must be served now: -1 none, 0 P0, 1 P1.
    function automatic int pick();
        bit e0, e1;
        e0 = (reset === 1'b0) && (q0.size() > 0) && (bus.pause_D0 === 1'b0);
        e1 = (reset === 1'b0) && (q1.size() > 0) && (bus.pause_D1 === 1'b0);
        if (e0 && e1) return 1 - m_last;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        int e;
        e = pick();
        if (armed) begin
            chk("pop_P0",       32'(bus.pop_P0),    32'(e == 0));
            chk("pop_P1",       32'(bus.pop_P1),    32'(e == 1));
            chk("Mux_out",      32'(bus.Mux_out),   32'(m_out));
            chk("Mux_valid",    32'(bus.Mux_valid), 32'(m_valid));
            chk("cnt_P0",       32'(bus.cnt_P0),    32'(m_cnt0));
            chk("cnt_P1",       32'(bus.cnt_P1),    32'(m_cnt1));
            chk("narrow_out",   32'(bus_w.Mux_out), 32'(m_out));
            chk("narrow_cnt0",  32'(bus_w.cnt_P0),  32'(m_cw0));
            chk("narrow_cnt1",  32'(bus_w.cnt_P1),  32'(m_cw1));
        end
        seen0 = bus.pop_P0;
        seen1 = bus.pop_P1;
    end

    always @(posedge clk) begin
        int e;
        e = pick();
        if (reset === 1'b1) begin
            m_out = 0; m_valid = 0; m_cnt0 = 0; m_cnt1 = 0; m_cw0 = 0; m_cw1 = 0;
            m_last = 1;
            armed = 1'b1;
        end else if (e == 0) begin
            m_out = int'(q0[0]) & ~32'h10;
            m_valid = 1; m_last = 0;
            m_cnt0 = (m_cnt0 + 1) % 256;
            m_cw0 = (m_cw0 + 1) % 4;
        end else if (e == 1) begin
            m_out = int'(q1[0]) | 32'h10;
            m_valid = 1; m_last = 1;
            m_cnt1 = (m_cnt1 + 1) % 256;
            m_cw1 = (m_cw1 + 1) % 4;
        end else begin
            m_out = 0; m_valid = 0;
        end
        #1;
        if (seen0 === 1'b1 && q0.size() > 0) void'(q0.pop_front());
        if (seen1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
        drive();
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.pause_D0 = 1'b0;
        bus.pause_D1 = 1'b0;
        q0.push_back(6'h2A);
        q1.push_back(6'h07);
        drive();

        // Reset held with both sources non-empty.
        @(negedge clk);
        chk("lit_rst_pop0", 32'(bus.pop_P0), 32'd0);
        chk("lit_rst_pop1", 32'(bus.pop_P1), 32'd0);
        step();
        @(negedge clk);
        chk("lit_rst_valid", 32'(bus.Mux_valid), 32'd0);
        chk("lit_rst_out",   32'(bus.Mux_out),   32'd0);
        chk("lit_rst_cnt0",  32'(bus.cnt_P0),    32'd0);
        step();
        reset = 1'b0;
        repeat (4) step();

        // Single source P0.
        do_reset();
        q0.push_back(6'h15);
        q0.push_back(6'h03);
        drive();
        @(negedge clk);
        chk("lit_single_pop_a", 32'(bus.pop_P0), 32'd1);
        step();
        @(negedge clk);
        chk("lit_single_pop_b", 32'(bus.pop_P0),    32'd1);
        chk("lit_single_w0",    32'(bus.Mux_out),   32'h05);
        chk("lit_single_v0",    32'(bus.Mux_valid), 32'd1);
        step();
        @(negedge clk);
        chk("lit_single_w1",   32'(bus.Mux_out), 32'h03);
        chk("lit_single_pop_c", 32'(bus.pop_P0), 32'd0);
        chk("lit_single_cnt",  32'(bus.cnt_P0),  32'd2);
        repeat (2) step();

        // Contention: strict alternation starting with P0.
        do_reset();
        q0.push_back(6'h30); q0.push_back(6'h31); q0.push_back(6'h32);
        q1.push_back(6'h01); q1.push_back(6'h02); q1.push_back(6'h03);
        drive();
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            chk("lit_rr_word",  32'(bus.Mux_out),   32'(lit_c[i]));
            chk("lit_rr_valid", 32'(bus.Mux_valid), 32'd1);
        end
        step();
        @(negedge clk);
        chk("lit_rr_idle", 32'(bus.Mux_valid), 32'd0);

        // Per-class pause on D1 for 4 cycles.
        do_reset();
        bus.pause_D1 = 1'b1;
        for (int i = 0; i < 5; i++) q0.push_back(6'(8'h0A + i));
        q1.push_back(6'h01);
        q1.push_back(6'h02);
        drive();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_pause_pop0", 32'(bus.pop_P0), 32'd1);
            chk("lit_pause_pop1", 32'(bus.pop_P1), 32'd0);
            step();
        end
        bus.pause_D1 = 1'b0;
        @(negedge clk);
        chk("lit_unpause_pop1", 32'(bus.pop_P1), 32'd1);
        repeat (6) step();

        // Reset in the same cycle as a P1 pop.
        do_reset();
        q1.push_back(6'h09);
        q1.push_back(6'h0A);
        drive();
        @(negedge clk);
        chk("lit_mid_pop1_a", 32'(bus.pop_P1), 32'd1);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("lit_mid_pop1_b", 32'(bus.pop_P1),  32'd0);
        chk("lit_mid_word",   32'(bus.Mux_out), 32'h19);
        step();
        @(negedge clk);
        chk("lit_mid_valid", 32'(bus.Mux_valid), 32'd0);
        chk("lit_mid_cnt1",  32'(bus.cnt_P1),    32'd0);
        step();
        reset = 1'b0;
        repeat (3) step();

        // Counter wrap on the 2-bit instance.
        do_reset();
        for (int i = 0; i < 5; i++) q0.push_back(6'(i + 1));
        drive();
        repeat (6) step();
        @(negedge clk);
        chk("lit_wrap_cnt0",  32'(bus_w.cnt_P0), 32'd1);
        chk("lit_wide_cnt0",  32'(bus.cnt_P0),   32'd5);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
